rl_lj_pair_dispatcher: RTL and testbench
========================================

Name: rl_lj_pair_dispatcher

Overview:
Producer side of the LJ pair-evaluation interface (r2_valid, r2, p_a, p_b). It holds one home particle and accepts a stream of neighbour particles in fixed point. For each neighbour it computes the squared distance and filters it against a cutoff. Pairs that pass are issued to the force evaluator as IEEE-754 single r2, together with p_a and p_b looked up by atom-type pair. It sits between the neighbour-cell readout and the force pipeline.

Parameters:
POS_WIDTH, 16, signed fixed-point coordinate width
POS_FRAC, 12, fractional bits of a coordinate (1.0 = 4096)
TYPE_WIDTH, 2, atom-type index width
DATA_WIDTH, 32, float width of r2, p_a and p_b

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
home_valid  in  1  load home particle (honoured only in IDLE)
home_x/home_y/home_z  in  POS_WIDTH  home coordinates
home_type  in  TYPE_WIDTH  home atom type
nb_valid  in  1  neighbour beat valid
nb_ready  out  1  dispatcher accepts neighbour
nb_x/nb_y/nb_z  in  POS_WIDTH  neighbour coordinates
nb_type  in  TYPE_WIDTH  neighbour atom type
nb_last  in  1  final neighbour for this home
cutoff_r2  in  2*POS_WIDTH+2  unsigned cutoff squared, same scale as the internal sum
param_wr_en  in  1  parameter table write
param_wr_addr  in  2*TYPE_WIDTH  address {type_i,type_j}
param_wr_pa/param_wr_pb  in  DATA_WIDTH  values to store
r2_valid  out  1  pair issued
r2/p_a/p_b  out  DATA_WIDTH  pair data, IEEE float
busy  out  1  state != IDLE
pair_done  out  1  one-cycle pulse when the home set is fully drained
stat_accepted/stat_filtered  out  16  counters (see Optional Feature)

Behaviour:
- Reset (rst==0 at posedge):
  - FSM goes to IDLE.
  - All pipeline valids, r2_valid, pair_done, r2, p_a, p_b, nb_ready and counters are cleared to 0.
  - The parameter table is not cleared.
  - Reset mid-stream discards in-flight pairs; nothing is issued afterwards.
- FSM:
  - IDLE: nb_ready=0. home_valid latches home_* and moves to STREAM.
  - STREAM: nb_ready=1. A beat is accepted when nb_valid&&nb_ready. An accepted beat with nb_last=1 moves to DRAIN.
  - DRAIN: nb_ready=0. Counts 4 cycles. On the cycle the last pipeline stage empties, pair_done=1 and the FSM returns to IDLE.
  - home_valid is ignored outside IDLE.
  - An nb_last arriving with nb_valid=0 has no effect.
- Pipeline: fixed 4 cycles from accept to r2_valid. One pair per cycle. There is no downstream backpressure, because the evaluator has none.
  - S1: dx, dy, dz = nb - home, each signed POS_WIDTH+1 bits. Register nb_type.
  - S2: squares, unsigned 2*POS_WIDTH+2 bits.
  - S3: S = dx²+dy²+dz², saturated to 2*POS_WIDTH+2 bits. keep = (S!=0) && (S<=cutoff_r2). S==0 means a self pair and is dropped. Read the table at {home_type, nb_type}.
  - S4: convert S to float and register the outputs. r2_valid = S3 valid && keep.
- Float conversion: value = S·2^-(2·POS_FRAC).
  - m = index of the leading one.
  - exponent = m - 2·POS_FRAC + 127. Sign = 0.
  - mantissa = the bits below m, left-aligned, truncated to 23 bits (round toward zero) and zero-padded if fewer than 23.
- Outputs on filtered or idle cycles: r2_valid=0; r2, p_a and p_b hold their last value.
- Parameter table:
  - 2^(2·TYPE_WIDTH) entries, register array.
  - Writes take effect the next cycle.
  - A write colliding with a read of the same address in S3 returns the old value.

Optional Feature:
Macro PAIR_DISPATCH_STATS_EN.
- Defined:
  - stat_accepted increments on every accepted neighbour beat.
  - stat_filtered increments on every S3 drop.
  - Both wrap at 2^16 and clear on reset and on a home load.
- Undefined: both outputs are constant 0 and no counter logic is built.

Decomposition:
- Shared package holds:
  - the SUM_W = 2*POS_WIDTH+2 localparam;
  - FLOAT_BIAS = 127;
  - the FSM state encoding (IDLE, STREAM, DRAIN);
  - the float constants 0x3F800000 etc. used by benches.
- One sub-module, rl_fix2float: combinational leading-one detect and pack, SUM_W in, 32 out, instantiated in S4.

Test Plan:
- Conversion, basic: home (0,0,0), cutoff 2^26; neighbour (4096,0,0) with nb_last -> 4 cycles later r2_valid=1, r2=0x3F800000, then pair_done 1 cycle after the drain completes.
- Conversion, range: neighbours (4096,4096,0), (2048,0,0), (-4096,0,0) back-to-back -> r2 = 0x40000000, 0x3E800000, 0x3F800000 on consecutive cycles.
- Cutoff: cutoff 25165824 (1.5); neighbours (4096,4096,0) and (4096,0,0) -> only 0x3F800000 is issued; stat_filtered=1 and stat_accepted=2 with PAIR_DISPATCH_STATS_EN.
- Self pair and parameters: write table[{1,2}] = pa 0x40400000, pb 0x3F000000; home type 1 at (100,100,100); neighbours type 2 at (100,100,100) then (4196,100,100) -> the first is dropped, the second issues r2=0x3F800000, p_a=0x40400000, p_b=0x3F000000.
- Handshake: nb_valid held with home_valid pulsed in STREAM -> the home is not reloaded. nb_ready=0 in IDLE and DRAIN, and no beat is accepted there.
- Reset: rst=0 for one cycle two cycles after a neighbour is accepted -> no r2_valid and no pair_done afterwards; all outputs are 0 and the FSM is in IDLE.

Source files
------------

// File: rtl/rl_lj_pair_dispatcher_pkg.sv
// Shared types and constants for the LJ pair dispatcher: default geometry,
// FSM encoding and reference float encodings.
package rl_lj_pair_dispatcher_pkg;

   localparam int POS_WIDTH_D  = 16;
   localparam int POS_FRAC_D   = 12;
   localparam int TYPE_WIDTH_D = 2;
   localparam int DATA_WIDTH_D = 32;

   localparam int SUM_W      = 2*POS_WIDTH_D+2;
   localparam int FLOAT_BIAS = 127;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DRAIN  = 2'd2
   } state_t;

   localparam logic [31:0] FP_ONE     = 32'h3F80_0000;
   localparam logic [31:0] FP_TWO     = 32'h4000_0000;
   localparam logic [31:0] FP_QUARTER = 32'h3E80_0000;
   localparam logic [31:0] FP_HALF    = 32'h3F00_0000;
   localparam logic [31:0] FP_THREE   = 32'h4040_0000;

endpackage

// File: rtl/rl_fix2float.sv
// Unsigned fixed-point to IEEE-754 single: leading-one detect, exponent
// rebias and truncating mantissa pack. Zero maps to +0.0.
module rl_fix2float
   import rl_lj_pair_dispatcher_pkg::*;
#(
   parameter int IN_W = SUM_W,
   parameter int FRAC = 24
) (
   input  logic [IN_W-1:0] value,
   output logic [31:0]     result
);

   int         m;
   logic       found;
   logic [7:0] expo;
   logic [22:0] mant;

   always_comb begin
      m     = 0;
      found = 1'b0;
      for (int i = 0; i < IN_W; i++) begin
         if (value[i]) begin
            m     = i;
            found = 1'b1;
         end
      end
      expo = 8'(m - FRAC + FLOAT_BIAS);
      // The leading one shifts out of the top, leaving the fraction bits left-aligned.
      mant = 23'(({value[IN_W-2:0], 23'd0} << (IN_W-1-m)) >> (IN_W-1));
      result = found ? {1'b0, expo, mant} : 32'd0;
   end

endmodule

// File: rtl/rl_lj_pair_dispatcher.sv
// Home/neighbour pair dispatcher: distance-squared, cutoff filter, float issue.
// Optional counters are built when PAIR_DISPATCH_STATS_EN is defined.
module rl_lj_pair_dispatcher
   import rl_lj_pair_dispatcher_pkg::*;
#(
   parameter int POS_WIDTH  = POS_WIDTH_D,
   parameter int POS_FRAC   = POS_FRAC_D,
   parameter int TYPE_WIDTH = TYPE_WIDTH_D,
   parameter int DATA_WIDTH = DATA_WIDTH_D
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    home_valid,
   input  logic [POS_WIDTH-1:0]    home_x,
   input  logic [POS_WIDTH-1:0]    home_y,
   input  logic [POS_WIDTH-1:0]    home_z,
   input  logic [TYPE_WIDTH-1:0]   home_type,
   input  logic                    nb_valid,
   output logic                    nb_ready,
   input  logic [POS_WIDTH-1:0]    nb_x,
   input  logic [POS_WIDTH-1:0]    nb_y,
   input  logic [POS_WIDTH-1:0]    nb_z,
   input  logic [TYPE_WIDTH-1:0]   nb_type,
   input  logic                    nb_last,
   input  logic [2*POS_WIDTH+1:0]  cutoff_r2,
   input  logic                    param_wr_en,
   input  logic [2*TYPE_WIDTH-1:0] param_wr_addr,
   input  logic [DATA_WIDTH-1:0]   param_wr_pa,
   input  logic [DATA_WIDTH-1:0]   param_wr_pb,
   output logic                    r2_valid,
   output logic [DATA_WIDTH-1:0]   r2,
   output logic [DATA_WIDTH-1:0]   p_a,
   output logic [DATA_WIDTH-1:0]   p_b,
   output logic                    busy,
   output logic                    pair_done,
   output logic [15:0]             stat_accepted,
   output logic [15:0]             stat_filtered,
   output state_t                  fsm_state
);

   localparam int SW   = 2*POS_WIDTH+2;
   localparam int DW   = POS_WIDTH+1;
   localparam int NENT = 2**(2*TYPE_WIDTH);

   state_t                 state, state_next;
   logic [1:0]             drain_cnt;
   logic                   pair_done_next;
   logic [POS_WIDTH-1:0]   hx, hy, hz;
   logic [TYPE_WIDTH-1:0]  htype;
   logic                   accept, home_load;

   // A neighbour beat transfers on a cycle where nb_valid && nb_ready; ready
   // depends only on state, never on nb_valid. The issue side has no ready.
   assign nb_ready  = (state == STREAM);
   assign accept    = nb_valid && nb_ready;
   assign home_load = (state == IDLE) && home_valid;
   assign busy      = (state != IDLE);
   assign fsm_state = state;

   always_comb begin
      state_next     = state;
      pair_done_next = 1'b0;
      case (state)
         IDLE:    if (home_valid) state_next = STREAM;
         STREAM:  if (accept && nb_last) state_next = DRAIN;
         DRAIN:   if (drain_cnt == 2'd3) begin
                     state_next     = IDLE;
                     pair_done_next = 1'b1;
                  end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         drain_cnt <= 2'd0;
         pair_done <= 1'b0;
      end else begin
         state     <= state_next;
         pair_done <= pair_done_next;
         drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : 2'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst && home_load) begin
         hx    <= home_x;
         hy    <= home_y;
         hz    <= home_z;
         htype <= home_type;
      end
   end

   logic                  s1_valid, s2_valid, s3_valid, s3_keep;
   logic signed [DW-1:0]  s1_dx, s1_dy, s1_dz;
   logic [TYPE_WIDTH-1:0] s1_type, s2_type;
   logic signed [SW-1:0]  sq_x, sq_y, sq_z;
   logic [SW-1:0]         s2_sx, s2_sy, s2_sz, s3_sum, sum_sat;
   logic [SW:0]           sum_wide;
   logic                  keep;
   logic [DATA_WIDTH-1:0] s3_pa, s3_pb;
   logic [31:0]           r2_float;
   logic [DATA_WIDTH-1:0] pa_tab [NENT];
   logic [DATA_WIDTH-1:0] pb_tab [NENT];

   always_comb begin
      sq_x     = SW'(s1_dx) * SW'(s1_dx);
      sq_y     = SW'(s1_dy) * SW'(s1_dy);
      sq_z     = SW'(s1_dz) * SW'(s1_dz);
      sum_wide = {1'b0, s2_sx} + {1'b0, s2_sy} + {1'b0, s2_sz};
      sum_sat  = sum_wide[SW] ? '1 : sum_wide[SW-1:0];
      // A zero distance is the home particle meeting itself.
      keep     = (sum_sat != '0) && (sum_sat <= cutoff_r2);
   end

   always_ff @(posedge clk) begin
      if (param_wr_en) begin
         pa_tab[param_wr_addr] <= param_wr_pa;
         pb_tab[param_wr_addr] <= param_wr_pb;
      end
   end

   always_ff @(posedge clk) begin
      s1_dx   <= {nb_x[POS_WIDTH-1], nb_x} - {hx[POS_WIDTH-1], hx};
      s1_dy   <= {nb_y[POS_WIDTH-1], nb_y} - {hy[POS_WIDTH-1], hy};
      s1_dz   <= {nb_z[POS_WIDTH-1], nb_z} - {hz[POS_WIDTH-1], hz};
      s1_type <= nb_type;
      s2_sx   <= $unsigned(sq_x);
      s2_sy   <= $unsigned(sq_y);
      s2_sz   <= $unsigned(sq_z);
      s2_type <= s1_type;
      s3_sum  <= sum_sat;
      s3_keep <= keep;
      s3_pa   <= pa_tab[{htype, s2_type}];
      s3_pb   <= pb_tab[{htype, s2_type}];
   end

   rl_fix2float #(.IN_W(SW), .FRAC(2*POS_FRAC)) u_fix2float (
      .value  (s3_sum),
      .result (r2_float)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
         s3_valid <= 1'b0;
         r2_valid <= 1'b0;
         r2       <= '0;
         p_a      <= '0;
         p_b      <= '0;
      end else begin
         s1_valid <= accept;
         s2_valid <= s1_valid;
         s3_valid <= s2_valid;
         r2_valid <= s3_valid && s3_keep;
         if (s3_valid && s3_keep) begin
            r2  <= DATA_WIDTH'(r2_float);
            p_a <= s3_pa;
            p_b <= s3_pb;
         end
      end
   end

`ifdef PAIR_DISPATCH_STATS_EN
   logic [15:0] acc_cnt, filt_cnt;

   always_ff @(posedge clk) begin
      if (!rst || home_load) begin
         acc_cnt  <= 16'd0;
         filt_cnt <= 16'd0;
      end else begin
         if (accept) acc_cnt <= acc_cnt + 16'd1;
         if (s2_valid && !keep) filt_cnt <= filt_cnt + 16'd1;
      end
   end

   assign stat_accepted = acc_cnt;
   assign stat_filtered = filt_cnt;
`else
   assign stat_accepted = 16'd0;
   assign stat_filtered = 16'd0;
`endif

endmodule

// File: tb/tb_rl_lj_pair_dispatcher.sv
// Directed bench for rl_lj_pair_dispatcher: latency, float packing, cutoff,
// self-pair drop, parameter lookup, handshake and mid-stream reset.
module tb_rl_lj_pair_dispatcher;
   import rl_lj_pair_dispatcher_pkg::*;

`ifdef PAIR_DISPATCH_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        home_valid;
   logic [15:0] home_x, home_y, home_z;
   logic [1:0]  home_type;
   logic        nb_valid, nb_ready, nb_last;
   logic [15:0] nb_x, nb_y, nb_z;
   logic [1:0]  nb_type;
   logic [33:0] cutoff_r2;
   logic        param_wr_en;
   logic [3:0]  param_wr_addr;
   logic [31:0] param_wr_pa, param_wr_pb;
   logic        r2_valid, busy, pair_done;
   logic [31:0] r2, p_a, p_b;
   logic [15:0] stat_accepted, stat_filtered;
   state_t      fsm_state;

   int vec_cnt = 0;
   int err_cnt = 0;

   logic [31:0] obs_r2[$];
   logic [31:0] obs_pa[$];
   logic [31:0] obs_pb[$];
   int          obs_cyc[$];
   int          pd_cnt, pd_cyc;
   int          bx[8], by[8], bz[8], bt[8];

   rl_lj_pair_dispatcher dut (
      .clk(clk), .rst(rst), .home_valid(home_valid),
      .home_x(home_x), .home_y(home_y), .home_z(home_z), .home_type(home_type),
      .nb_valid(nb_valid), .nb_ready(nb_ready),
      .nb_x(nb_x), .nb_y(nb_y), .nb_z(nb_z), .nb_type(nb_type), .nb_last(nb_last),
      .cutoff_r2(cutoff_r2), .param_wr_en(param_wr_en), .param_wr_addr(param_wr_addr),
      .param_wr_pa(param_wr_pa), .param_wr_pb(param_wr_pb),
      .r2_valid(r2_valid), .r2(r2), .p_a(p_a), .p_b(p_b),
      .busy(busy), .pair_done(pair_done),
      .stat_accepted(stat_accepted), .stat_filtered(stat_filtered),
      .fsm_state(fsm_state)
   );

   always #5 clk = ~clk;

   task automatic do_reset();
      @(negedge clk); rst = 1'b0;
      @(negedge clk);
      @(negedge clk); rst = 1'b1;
   endtask

   task automatic write_param(input int addr, input logic [31:0] pa, input logic [31:0] pb);
      @(negedge clk);
      param_wr_en = 1'b1; param_wr_addr = 4'(addr); param_wr_pa = pa; param_wr_pb = pb;
      @(negedge clk);
      param_wr_en = 1'b0;
   endtask

   task automatic load_home(input int x, input int y, input int z, input int t);
      @(negedge clk);
      home_x = 16'(x); home_y = 16'(y); home_z = 16'(z); home_type = 2'(t);
      home_valid = 1'b1;
      @(negedge clk);
      home_valid = 1'b0;
   endtask

   task automatic clear_obs();
      obs_r2.delete(); obs_pa.delete(); obs_pb.delete(); obs_cyc.delete();
      pd_cnt = 0; pd_cyc = -1;
   endtask

   task automatic sample(input int t);
      if (r2_valid) begin
         obs_r2.push_back(r2); obs_pa.push_back(p_a); obs_pb.push_back(p_b);
         obs_cyc.push_back(t);
      end
      if (pair_done) begin
         pd_cnt++; pd_cyc = t;
      end
   endtask

   task automatic set_beat(input int x, input int y, input int z, input int t, input logic last);
      nb_valid = 1'b1; nb_x = 16'(x); nb_y = 16'(y); nb_z = 16'(z); nb_type = 2'(t); nb_last = last;
   endtask

   // Beat i is driven at sample slot i; its pair appears at slot i+4.
   task automatic run_stream(input int n);
      clear_obs();
      for (int t = 0; t < n + 12; t++) begin
         @(negedge clk);
         sample(t);
         if (t < n) set_beat(bx[t], by[t], bz[t], bt[t], t == n-1);
         else begin nb_valid = 1'b0; nb_last = 1'b0; end
      end
   endtask

   task automatic test_reset();
      vec_cnt++; if (r2_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_r2_valid got %b want 0", r2_valid); end
      vec_cnt++; if (r2 !== 32'd0) begin err_cnt++; $display("FAIL reset_r2 got %h want 0", r2); end
      vec_cnt++; if (p_a !== 32'd0 || p_b !== 32'd0) begin err_cnt++; $display("FAIL reset_params got %h/%h want 0/0", p_a, p_b); end
      vec_cnt++; if (nb_ready !== 1'b0) begin err_cnt++; $display("FAIL reset_nb_ready got %b want 0", nb_ready); end
      vec_cnt++; if (busy !== 1'b0 || fsm_state !== IDLE) begin err_cnt++; $display("FAIL reset_state busy %b state %0d want 0/IDLE", busy, fsm_state); end
      vec_cnt++; if (pair_done !== 1'b0) begin err_cnt++; $display("FAIL reset_pair_done got %b want 0", pair_done); end
      vec_cnt++; if (stat_accepted !== 16'd0 || stat_filtered !== 16'd0) begin err_cnt++; $display("FAIL reset_stats got %0d/%0d want 0/0", stat_accepted, stat_filtered); end
   endtask

   task automatic test_basic();
      cutoff_r2 = 34'd67108864;
      load_home(0, 0, 0, 0);
      vec_cnt++; if (nb_ready !== 1'b1 || fsm_state !== STREAM) begin err_cnt++; $display("FAIL basic_stream_entry ready %b state %0d want 1/STREAM", nb_ready, fsm_state); end
      bx[0] = 4096; by[0] = 0; bz[0] = 0; bt[0] = 0;
      run_stream(1);
      vec_cnt++; if (obs_r2.size() != 1) begin err_cnt++; $display("FAIL basic_count got %0d want 1", obs_r2.size()); end
      if (obs_r2.size() >= 1) begin
         vec_cnt++; if (obs_r2[0] !== FP_ONE) begin err_cnt++; $display("FAIL basic_r2 got %h want %h", obs_r2[0], FP_ONE); end
         vec_cnt++; if (obs_cyc[0] != 4) begin err_cnt++; $display("FAIL basic_latency got %0d want 4", obs_cyc[0]); end
         vec_cnt++; if (obs_pa[0] !== 32'h4100_0000 || obs_pb[0] !== 32'h4200_0000) begin err_cnt++; $display("FAIL basic_params got %h/%h want 41000000/42000000", obs_pa[0], obs_pb[0]); end
      end
      vec_cnt++; if (pd_cnt != 1 || pd_cyc != 5) begin err_cnt++; $display("FAIL basic_pair_done got %0d pulses at %0d want 1 at 5", pd_cnt, pd_cyc); end
      vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL basic_idle busy got %b want 0", busy); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_r2 [6] = '{32'h4000_0000, 32'h3E80_0000, 32'h3F80_0000,
                                  32'h4010_0000, 32'h3F80_1000, 32'h3380_0000};
      cutoff_r2 = 34'd67108864;
      load_home(0, 0, 0, 0);
      bx = '{4096, 2048, -4096, 6144, 4097, 1, 0, 0};
      by = '{4096, 0, 0, 0, 0, 0, 0, 0};
      bz = '{0, 0, 0, 0, 0, 0, 0, 0};
      bt = '{0, 0, 0, 0, 0, 0, 0, 0};
      run_stream(6);
      vec_cnt++; if (obs_r2.size() != 6) begin err_cnt++; $display("FAIL b2b_count got %0d want 6", obs_r2.size()); end
      for (int j = 0; j < 6; j++) begin
         if (j < obs_r2.size()) begin
            vec_cnt++; if (obs_r2[j] !== exp_r2[j]) begin err_cnt++; $display("FAIL b2b_r2[%0d] got %h want %h", j, obs_r2[j], exp_r2[j]); end
            vec_cnt++; if (obs_cyc[j] != j + 4) begin err_cnt++; $display("FAIL b2b_cycle[%0d] got %0d want %0d", j, obs_cyc[j], j + 4); end
         end
      end
      vec_cnt++; if (pd_cnt != 1 || pd_cyc != 10) begin err_cnt++; $display("FAIL b2b_pair_done got %0d pulses at %0d want 1 at 10", pd_cnt, pd_cyc); end
   endtask

   task automatic test_cutoff();
      logic [15:0] exp_acc = STATS ? 16'd2 : 16'd0;
      logic [15:0] exp_flt = STATS ? 16'd1 : 16'd0;
      cutoff_r2 = 34'd25165824;
      load_home(0, 0, 0, 0);
      bx = '{4096, 4096, 0, 0, 0, 0, 0, 0};
      by = '{4096, 0, 0, 0, 0, 0, 0, 0};
      bz = '{0, 0, 0, 0, 0, 0, 0, 0};
      bt = '{0, 0, 0, 0, 0, 0, 0, 0};
      run_stream(2);
      vec_cnt++; if (obs_r2.size() != 1) begin err_cnt++; $display("FAIL cut15_count got %0d want 1", obs_r2.size()); end
      if (obs_r2.size() >= 1) begin
         vec_cnt++; if (obs_r2[0] !== FP_ONE || obs_cyc[0] != 5) begin err_cnt++; $display("FAIL cut15_pair got %h at %0d want %h at 5", obs_r2[0], obs_cyc[0], FP_ONE); end
      end
      vec_cnt++; if (stat_accepted !== exp_acc || stat_filtered !== exp_flt) begin err_cnt++; $display("FAIL cut15_stats got %0d/%0d want %0d/%0d", stat_accepted, stat_filtered, exp_acc, exp_flt); end
      // Exactly at the cutoff passes; one LSB beyond it is dropped.
      cutoff_r2 = 34'd16777216;
      load_home(0, 0, 0, 0);
      vec_cnt++; if (stat_accepted !== 16'd0 || stat_filtered !== 16'd0) begin err_cnt++; $display("FAIL home_load_stats got %0d/%0d want 0/0", stat_accepted, stat_filtered); end
      bx = '{4096, 4097, 0, 0, 0, 0, 0, 0};
      by = '{0, 0, 0, 0, 0, 0, 0, 0};
      run_stream(2);
      vec_cnt++; if (obs_r2.size() != 1) begin err_cnt++; $display("FAIL cut_edge_count got %0d want 1", obs_r2.size()); end
      if (obs_r2.size() >= 1) begin
         vec_cnt++; if (obs_r2[0] !== FP_ONE || obs_cyc[0] != 4) begin err_cnt++; $display("FAIL cut_edge_pair got %h at %0d want %h at 4", obs_r2[0], obs_cyc[0], FP_ONE); end
      end
      vec_cnt++; if (stat_accepted !== exp_acc || stat_filtered !== exp_flt) begin err_cnt++; $display("FAIL cut_edge_stats got %0d/%0d want %0d/%0d", stat_accepted, stat_filtered, exp_acc, exp_flt); end
   endtask

   task automatic test_self_param();
      cutoff_r2 = 34'd67108864;
      write_param(6, FP_THREE, FP_HALF);
      load_home(100, 100, 100, 1);
      bx = '{100, 4196, 0, 0, 0, 0, 0, 0};
      by = '{100, 100, 0, 0, 0, 0, 0, 0};
      bz = '{100, 100, 0, 0, 0, 0, 0, 0};
      bt = '{2, 2, 0, 0, 0, 0, 0, 0};
      run_stream(2);
      vec_cnt++; if (obs_r2.size() != 1) begin err_cnt++; $display("FAIL self_count got %0d want 1", obs_r2.size()); end
      if (obs_r2.size() >= 1) begin
         vec_cnt++; if (obs_r2[0] !== FP_ONE || obs_cyc[0] != 5) begin err_cnt++; $display("FAIL self_r2 got %h at %0d want %h at 5", obs_r2[0], obs_cyc[0], FP_ONE); end
         vec_cnt++; if (obs_pa[0] !== FP_THREE) begin err_cnt++; $display("FAIL self_pa got %h want %h", obs_pa[0], FP_THREE); end
         vec_cnt++; if (obs_pb[0] !== FP_HALF) begin err_cnt++; $display("FAIL self_pb got %h want %h", obs_pb[0], FP_HALF); end
      end
   endtask

   task automatic test_handshake();
      logic [31:0] exp_r2 [3] = '{FP_ONE, FP_ONE, FP_QUARTER};
      cutoff_r2 = 34'd67108864;
      clear_obs();
      @(negedge clk);
      set_beat(4096, 0, 0, 0, 1'b1);
      for (int t = 0; t < 3; t++) begin
         @(negedge clk); sample(t);
         vec_cnt++; if (nb_ready !== 1'b0 || busy !== 1'b0) begin err_cnt++; $display("FAIL hs_idle[%0d] ready %b busy %b want 0/0", t, nb_ready, busy); end
      end
      home_x = 16'd0; home_y = 16'd0; home_z = 16'd0; home_type = 2'd0; home_valid = 1'b1;
      @(negedge clk); sample(3);
      vec_cnt++; if (nb_ready !== 1'b1) begin err_cnt++; $display("FAIL hs_stream_ready got %b want 1", nb_ready); end
      home_x = 16'd8192; home_valid = 1'b1;
      set_beat(4096, 0, 0, 0, 1'b0);
      @(negedge clk); sample(4);
      home_valid = 1'b0;
      set_beat(0, 4096, 0, 0, 1'b0);
      @(negedge clk); sample(5);
      set_beat(2048, 0, 0, 0, 1'b1);
      @(negedge clk); sample(6);
      vec_cnt++; if (nb_ready !== 1'b0 || fsm_state !== DRAIN) begin err_cnt++; $display("FAIL hs_drain ready %b state %0d want 0/DRAIN", nb_ready, fsm_state); end
      set_beat(4096, 4096, 0, 0, 1'b1);
      for (int t = 7; t < 18; t++) begin
         @(negedge clk); sample(t);
      end
      nb_valid = 1'b0; nb_last = 1'b0;
      vec_cnt++; if (obs_r2.size() != 3) begin err_cnt++; $display("FAIL hs_count got %0d want 3", obs_r2.size()); end
      for (int j = 0; j < 3; j++) begin
         if (j < obs_r2.size()) begin
            vec_cnt++; if (obs_r2[j] !== exp_r2[j] || obs_cyc[j] != j + 7) begin err_cnt++; $display("FAIL hs_pair[%0d] got %h at %0d want %h at %0d", j, obs_r2[j], obs_cyc[j], exp_r2[j], j + 7); end
         end
      end
      vec_cnt++; if (pd_cnt != 1 || pd_cyc != 10) begin err_cnt++; $display("FAIL hs_pair_done got %0d pulses at %0d want 1 at 10", pd_cnt, pd_cyc); end
      vec_cnt++; if (fsm_state !== IDLE) begin err_cnt++; $display("FAIL hs_final_state got %0d want IDLE", fsm_state); end
   endtask

   task automatic test_reset_mid();
      cutoff_r2 = 34'd67108864;
      load_home(0, 0, 0, 0);
      clear_obs();
      @(negedge clk);
      set_beat(4096, 0, 0, 0, 1'b0);
      @(negedge clk);
      nb_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      vec_cnt++; if (r2_valid !== 1'b0 || r2 !== 32'd0 || p_a !== 32'd0 || p_b !== 32'd0) begin err_cnt++; $display("FAIL rmid_outputs got v%b %h %h %h want all 0", r2_valid, r2, p_a, p_b); end
      vec_cnt++; if (busy !== 1'b0 || nb_ready !== 1'b0 || fsm_state !== IDLE) begin err_cnt++; $display("FAIL rmid_state busy %b ready %b state %0d want 0/0/IDLE", busy, nb_ready, fsm_state); end
      vec_cnt++; if (stat_accepted !== 16'd0 || stat_filtered !== 16'd0) begin err_cnt++; $display("FAIL rmid_stats got %0d/%0d want 0/0", stat_accepted, stat_filtered); end
      for (int t = 0; t < 8; t++) begin
         @(negedge clk); sample(t);
      end
      vec_cnt++; if (obs_r2.size() != 0 || pd_cnt != 0) begin err_cnt++; $display("FAIL rmid_quiet got %0d pairs %0d done want 0/0", obs_r2.size(), pd_cnt); end
      // The parameter table survives reset.
      load_home(0, 0, 0, 0);
      bx[0] = 0; by[0] = 0; bz[0] = 4096; bt[0] = 0;
      run_stream(1);
      vec_cnt++; if (obs_r2.size() != 1) begin err_cnt++; $display("FAIL rmid_after_count got %0d want 1", obs_r2.size()); end
      if (obs_r2.size() >= 1) begin
         vec_cnt++; if (obs_r2[0] !== FP_ONE || obs_pa[0] !== 32'h4100_0000) begin err_cnt++; $display("FAIL rmid_table got %h/%h want %h/41000000", obs_r2[0], obs_pa[0], FP_ONE); end
      end
   endtask

   initial begin
      rst = 1'b0; home_valid = 1'b0; home_x = '0; home_y = '0; home_z = '0; home_type = '0;
      nb_valid = 1'b0; nb_last = 1'b0; nb_x = '0; nb_y = '0; nb_z = '0; nb_type = '0;
      cutoff_r2 = '0; param_wr_en = 1'b0; param_wr_addr = '0; param_wr_pa = '0; param_wr_pb = '0;
      do_reset();
      test_reset();
      for (int a = 0; a < 16; a++) write_param(a, 32'h4100_0000 | 32'(a), 32'h4200_0000 | 32'(a));
      test_basic();
      test_back_to_back();
      test_cutoff();
      test_self_param();
      test_handshake();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
